// File: rtl/effect_xfade_slot.sv
// effect_xfade_slot: click-free bypass/insert slot for one effect stage.
// The dry sample is delayed by the effect's latency so that it lines up with
// the wet sample. On enable changes the output ramps linearly between dry and
// wet over 2^RAMP_BITS samples instead of switching hard.
module effect_xfade_slot #(
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 8,
    parameter int RAMP_BITS  = 6
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sample_valid,
    input  logic signed [DATA_WIDTH-1:0] dry_in,
    input  logic signed [DATA_WIDTH-1:0] wet_in,
    input  logic                         wet_valid,
    input  logic                         enable,
    output logic signed [DATA_WIDTH-1:0] audio_out,
    output logic                         audio_out_valid,
    output logic                         active,
    output logic                         busy,
    output logic                         align_error
);

    // Mix width: a DATA_WIDTH sample times a gain of up to 2^RAMP_BITS, plus sign and headroom
    localparam int MIX_W = DATA_WIDTH + RAMP_BITS + 2;
    localparam int FULL  = 1 << RAMP_BITS;

    localparam logic [RAMP_BITS:0] G_ZERO = '0;
    localparam logic [RAMP_BITS:0] G_ONE  = (RAMP_BITS+1)'(1);
    localparam logic [RAMP_BITS:0] G_FULL = (RAMP_BITS+1)'(FULL);
    localparam logic [RAMP_BITS:0] G_LAST = (RAMP_BITS+1)'(FULL - 1);

    typedef enum logic [1:0] {
        BYPASS   = 2'd0,
        FADE_IN  = 2'd1,
        WET      = 2'd2,
        FADE_OUT = 2'd3
    } xfade_state_t;

    // Weighted sum of wet and dry, floored back to sample scale by the arithmetic shift.
    // The result is a convex combination, so truncation to DATA_WIDTH never wraps.
    function automatic logic signed [DATA_WIDTH-1:0] xfade_mix(
        input logic signed [DATA_WIDTH-1:0] wet,
        input logic signed [DATA_WIDTH-1:0] dry,
        input logic        [RAMP_BITS:0]    gain
    );
        logic        [RAMP_BITS:0] inv_gain;
        logic signed [MIX_W-1:0]   wet_x;
        logic signed [MIX_W-1:0]   dry_x;
        logic signed [MIX_W-1:0]   g_x;
        logic signed [MIX_W-1:0]   ig_x;
        logic signed [MIX_W-1:0]   sum_x;
        inv_gain = G_FULL - gain;
        wet_x    = {{(RAMP_BITS+2){wet[DATA_WIDTH-1]}}, wet};
        dry_x    = {{(RAMP_BITS+2){dry[DATA_WIDTH-1]}}, dry};
        g_x      = {{(DATA_WIDTH+1){1'b0}}, gain};
        ig_x     = {{(DATA_WIDTH+1){1'b0}}, inv_gain};
        sum_x    = (wet_x * g_x) + (dry_x * ig_x);
        xfade_mix = DATA_WIDTH'(sum_x >>> RAMP_BITS);
    endfunction

    logic signed [DATA_WIDTH-1:0] dry_p0 [0:LATENCY-1];
    logic                         vld_p0 [0:LATENCY-1];
    logic signed [DATA_WIDTH-1:0] dry_d;
    logic                         strobe_d;
    logic [RAMP_BITS:0]           g;
    xfade_state_t                 state;

    // ---- stage p0: dry latency compensation ----
    assign dry_d    = dry_p0[LATENCY-1];
    assign strobe_d = vld_p0[LATENCY-1];

    // Shift dry sample and its strobe down the delay line every clock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                dry_p0[i] <= '0;
                vld_p0[i] <= 1'b0;
            end
        end else begin
            dry_p0[0] <= dry_in;
            vld_p0[0] <= sample_valid;
            for (int i = 1; i < LATENCY; i++) begin
                dry_p0[i] <= dry_p0[i-1];
                vld_p0[i] <= vld_p0[i-1];
            end
        end
    end

    // ---- stage p1: mix and output register ----
    // Mix with the gain as it stands before this strobe's update; hold between strobes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            audio_out       <= '0;
            audio_out_valid <= 1'b0;
        end else begin
            audio_out_valid <= strobe_d;
            if (strobe_d) begin
                audio_out <= xfade_mix(wet_in, dry_d, g);
            end
        end
    end

    // Sticky flag whenever the effect's strobe disagrees with the delayed dry strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            align_error <= 1'b0;
        end else if (wet_valid != strobe_d) begin
            align_error <= 1'b1;
        end
    end

    // Crossfade state machine; steps the gain one notch per aligned sample
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= BYPASS;
            g      <= G_ZERO;
            active <= 1'b0;
            busy   <= 1'b0;
        end else if (strobe_d) begin
            case (state)
                BYPASS: begin
                    if (enable) begin
                        g      <= G_ONE;
                        state  <= FADE_IN;
                        active <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                FADE_IN, FADE_OUT: begin
                    // A reversal mid-fade simply walks g back from where it is
                    if (enable) begin
                        g      <= g + G_ONE;
                        active <= 1'b1;
                        if (g == G_LAST) begin
                            state <= WET;
                            busy  <= 1'b0;
                        end else begin
                            state <= FADE_IN;
                            busy  <= 1'b1;
                        end
                    end else begin
                        g <= g - G_ONE;
                        if (g == G_ONE) begin
                            state  <= BYPASS;
                            active <= 1'b0;
                            busy   <= 1'b0;
                        end else begin
                            state  <= FADE_OUT;
                            active <= 1'b1;
                            busy   <= 1'b1;
                        end
                    end
                end
                WET: begin
                    if (!enable) begin
                        g      <= G_LAST;
                        state  <= FADE_OUT;
                        active <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                default: begin
                    state  <= BYPASS;
                    g      <= G_ZERO;
                    active <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_effect_xfade_slot.sv
// Testbench for effect_xfade_slot (DATA_WIDTH=16, LATENCY=4, RAMP_BITS=3).
module tb_effect_xfade_slot;

    localparam int DW   = 16;
    localparam int LAT  = 4;
    localparam int RB   = 3;
    localparam int FULL = 8;
    localparam int RCYC = 600;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 sample_valid = 1'b0;
    logic signed [DW-1:0] dry_in = '0;
    logic signed [DW-1:0] wet_in = '0;
    logic                 wet_valid = 1'b0;
    logic                 enable = 1'b0;
    logic signed [DW-1:0] audio_out;
    logic                 audio_out_valid;
    logic                 active;
    logic                 busy;
    logic                 align_error;

    int n_assert = 0;
    int n_fail   = 0;

    effect_xfade_slot #(
        .DATA_WIDTH(DW),
        .LATENCY   (LAT),
        .RAMP_BITS (RB)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .sample_valid   (sample_valid),
        .dry_in         (dry_in),
        .wet_in         (wet_in),
        .wet_valid      (wet_valid),
        .enable         (enable),
        .audio_out      (audio_out),
        .audio_out_valid(audio_out_valid),
        .active         (active),
        .busy           (busy),
        .align_error    (align_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int dry;
        int wet;
        int gain;
        int exp_out;
    } mix_vec_t;

    mix_vec_t vecs [10];

    task automatic check(input string nm, input longint act, input longint exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Reference mix: floor((wet*g + dry*(FULL-g)) / FULL) with plain integer math
    function automatic longint mix_ref(input longint w, input longint d, input longint gn);
        longint num;
        longint q;
        num = w * gn + d * (FULL - gn);
        q = num / FULL;
        if ((num % FULL != 0) && (num < 0)) q = q - 1;
        return q;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        sample_valid = 1'b0;
        wet_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One dry sample, with its wet partner delivered LAT cycles later; enable applied on the aligned cycle
    task automatic send(input int d, input int w, input logic en, output int out, output logic vld);
        @(negedge clk);
        sample_valid = 1'b1;
        dry_in = DW'(d);
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (LAT - 1) @(negedge clk);
        wet_valid = 1'b1;
        wet_in = DW'(w);
        enable = en;
        @(negedge clk);
        wet_valid = 1'b0;
        out = int'(audio_out);
        vld = audio_out_valid;
    endtask

    initial begin
        int   out;
        logic vld;
        int   first;
        int   width;
        int   out1;
        int   sv_h  [RCYC];
        int   dry_h [RCYC];
        int   wet_h [RCYC];
        logic en_cur;
        int   g_m;
        int   out_m;
        logic strobe;

        vecs[0] = '{1000, 1000, 0, 1000};
        vecs[1] = '{1000, -1000, 3, 250};
        vecs[2] = '{0, -1, 1, -1};
        vecs[3] = '{0, 1, 1, 0};
        vecs[4] = '{1000, -1000, 8, -1000};
        vecs[5] = '{-32768, 32767, 0, -32768};
        vecs[6] = '{-32768, 32767, 8, 32767};
        vecs[7] = '{-32768, 32767, 4, -1};
        vecs[8] = '{-7, 5, 5, 0};
        vecs[9] = '{-7, 5, 3, -3};

        // Asynchronous reset state, no clock edge needed
        #2 reset = 1'b1;
        #2;
        check("rst_audio_out", int'(audio_out), 0);
        check("rst_valid", audio_out_valid, 0);
        check("rst_active", active, 0);
        check("rst_busy", busy, 0);
        check("rst_align_error", align_error, 0);
        @(negedge clk);
        reset = 1'b0;

        // Bypass passthrough: latency and single-cycle valid pulse
        do_reset();
        enable = 1'b0;
        @(negedge clk);
        sample_valid = 1'b1;
        dry_in = 16'sd1000;
        wet_in = 16'sd1000;
        first = -1;
        width = 0;
        out1 = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) sample_valid = 1'b0;
            wet_valid = (c == LAT);
            if (audio_out_valid) begin
                if (first < 0) begin
                    first = c;
                    out1 = int'(audio_out);
                end
                width++;
            end
        end
        wet_valid = 1'b0;
        check("bypass_latency", first, LAT + 1);
        check("bypass_valid_width", width, 1);
        check("bypass_out", out1, 1000);
        check("bypass_active", active, 0);

        // Table of mix points reached by ramping g up from reset
        for (int v = 0; v < 10; v++) begin
            do_reset();
            for (int s = 0; s < vecs[v].gain; s++) send(0, 0, 1'b1, out, vld);
            send(vecs[v].dry, vecs[v].wet, 1'b1, out, vld);
            check($sformatf("vec%0d_valid", v), vld, 1);
            check($sformatf("vec%0d_out", v), out, vecs[v].exp_out);
        end

        // Full fade in
        do_reset();
        for (int i = 0; i < 10; i++) begin
            send(1000, -1000, 1'b1, out, vld);
            check($sformatf("fadein_out%0d", i), out, 1000 - 250 * ((i < FULL) ? i : FULL));
            check($sformatf("fadein_busy%0d", i), busy, (i + 1 < FULL) ? 1 : 0);
        end
        check("fadein_active", active, 1);

        // Reversal at g=3
        do_reset();
        for (int i = 0; i < 3; i++) send(1000, -1000, 1'b1, out, vld);
        for (int i = 0; i < 4; i++) begin
            send(1000, -1000, 1'b0, out, vld);
            check($sformatf("reverse_out%0d", i), out, 250 + 250 * i);
            if (i == 2) begin
                check("reverse_busy_end", busy, 0);
                check("reverse_active_end", active, 0);
            end
        end

        // Misalignment: wet strobe one cycle late
        do_reset();
        enable = 1'b0;
        @(negedge clk);
        sample_valid = 1'b1;
        dry_in = 16'sd500;
        wet_in = 16'sd500;
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (LAT - 1) @(negedge clk);
        @(negedge clk);
        check("misalign_valid", audio_out_valid, 1);
        check("misalign_out", int'(audio_out), 500);
        check("misalign_flag", align_error, 1);
        wet_valid = 1'b1;
        @(negedge clk);
        wet_valid = 1'b0;
        check("misalign_valid_low", audio_out_valid, 0);
        send(200, 200, 1'b0, out, vld);
        check("misalign_next_out", out, 200);
        check("misalign_sticky", align_error, 1);

        // Asynchronous reset mid-fade at g=5
        do_reset();
        for (int i = 0; i < 5; i++) send(1000, 3000, 1'b1, out, vld);
        check("midfade_out_before", out, 2000);
        reset = 1'b1;
        #1;
        check("async_rst_out", int'(audio_out), 0);
        check("async_rst_valid", audio_out_valid, 0);
        check("async_rst_active", active, 0);
        check("async_rst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        send(1234, 9999, 1'b1, out, vld);
        check("post_rst_out", out, 1234);
        check("post_rst_active", active, 1);
        check("post_rst_busy", busy, 1);

        // Randomised traffic against the reference model
        do_reset();
        en_cur = 1'b0;
        g_m = 0;
        out_m = 0;
        for (int j = 0; j < RCYC; j++) begin
            sv_h[j] = ($urandom_range(0, 2) != 0) ? 1 : 0;
            if ($urandom_range(0, 3) == 0) begin
                dry_h[j] = int'($urandom_range(0, 16)) - 8;
                wet_h[j] = int'($urandom_range(0, 16)) - 8;
            end else begin
                dry_h[j] = int'($urandom_range(0, 65535)) - 32768;
                wet_h[j] = int'($urandom_range(0, 65535)) - 32768;
            end
            if ($urandom_range(0, 15) == 0) en_cur = ~en_cur;
            sample_valid = (sv_h[j] != 0);
            dry_in = DW'(dry_h[j]);
            strobe = (j >= LAT) && (sv_h[(j >= LAT) ? j - LAT : 0] != 0);
            if (strobe) begin
                wet_valid = 1'b1;
                wet_in = DW'(wet_h[j - LAT]);
            end else begin
                wet_valid = 1'b0;
                wet_in = DW'($urandom);
            end
            enable = en_cur;
            @(negedge clk);
            if (strobe) begin
                out_m = int'(mix_ref(wet_h[j - LAT], dry_h[j - LAT], g_m));
                if (en_cur) g_m = (g_m < FULL) ? g_m + 1 : FULL;
                else        g_m = (g_m > 0) ? g_m - 1 : 0;
            end
            check("rand_valid", audio_out_valid, strobe);
            check("rand_out", int'(audio_out), out_m);
            check("rand_active", active, (g_m != 0) ? 1 : 0);
            check("rand_busy", busy, (g_m != 0 && g_m != FULL) ? 1 : 0);
            check("rand_align", align_error, 0);
        end
        sample_valid = 1'b0;
        wet_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
